// File: rtl/iir_coeff_ctrl.sv
// Coefficient bank controller for the biquad notch stage: shadow bank, preset load,
// atomic commit in an idle sample slot, readback verify and post-update bypass.
module iir_coeff_ctrl #(
  parameter int COEFF_WIDTH    = 20,
  parameter int COEFF_DEPTH    = 5,
  parameter int NOTCH_DEFAULT  = 2,
  parameter int GAP_TIMEOUT    = 64,
  parameter int SETTLE_SAMPLES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_wr_en,
  input  logic [2:0]                             cfg_addr,
  input  logic [COEFF_WIDTH-1:0]                 cfg_wdata,
  input  logic [2:0]                             cfg_rd_addr,
  output logic [COEFF_WIDTH-1:0]                 cfg_rdata,
  output logic [COEFF_WIDTH-1:0]                 live_rdata,
  input  logic                                   preset_load,
  input  logic [1:0]                             preset_sel,
  input  logic                                   commit_req,
  input  logic                                   bypass_cfg,
  input  logic                                   valid_in,
  output logic                                   coeff_wr_en,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_out,
  output logic                                   iir_bypass,
  output logic                                   busy,
  output logic                                   commit_done,
  output logic                                   cfg_err,
  output logic                                   verify_err,
  output logic                                   forced_commit
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_SAMPLES + 2);

  typedef logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] bank_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GAP, S_COMMIT, S_VERIFY, S_SETTLE, S_DONE
  } state_t;

  state_t        state;
  bank_t         shadow;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] settle_cnt;

  // Presets differ only in the B1/A1 term that places the notch.
  function automatic bank_t preset_bank(input logic [1:0] sel);
    bank_t                  b;
    logic [COEFF_WIDTH-1:0] mid;
    case (sel)
      2'd0:    mid = COEFF_WIDTH'(20'hc8f9f);
      2'd1:    mid = COEFF_WIDTH'(20'h37061);
      default: mid = COEFF_WIDTH'(20'h5907c);
    endcase
    b    = '0;
    b[0] = COEFF_WIDTH'(20'h37061);
    b[1] = mid;
    b[2] = COEFF_WIDTH'(20'h37061);
    b[3] = mid;
    b[4] = COEFF_WIDTH'(20'h2e0c3);
    return b;
  endfunction

  logic addr_ok, sel_ok, any_req;
  assign addr_ok = int'(cfg_addr) < COEFF_DEPTH;
  assign sel_ok  = preset_sel != 2'd3;
  assign any_req = cfg_wr_en | preset_load | commit_req;

  assign coeff_in   = shadow;
  assign cfg_rdata  = (int'(cfg_rd_addr) < COEFF_DEPTH) ? shadow[cfg_rd_addr] : '0;
  assign live_rdata = (int'(cfg_rd_addr) < COEFF_DEPTH) ? coeff_out[cfg_rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      shadow        <= preset_bank(2'(NOTCH_DEFAULT));
      gap_cnt       <= '0;
      settle_cnt    <= '0;
      coeff_wr_en   <= 1'b0;
      iir_bypass    <= 1'b0;
      busy          <= 1'b0;
      commit_done   <= 1'b0;
      cfg_err       <= 1'b0;
      verify_err    <= 1'b0;
      forced_commit <= 1'b0;
    end else begin
      coeff_wr_en <= 1'b0;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
      iir_bypass  <= bypass_cfg;

      if (state != S_IDLE && any_req) cfg_err <= 1'b1;

      case (state)
        S_IDLE: begin
          // A preset wins over a same-cycle single write; the write is reported.
          if (preset_load) begin
            if (sel_ok) shadow <= preset_bank(preset_sel);
            if (!sel_ok || cfg_wr_en) cfg_err <= 1'b1;
          end else if (cfg_wr_en) begin
            if (addr_ok) shadow[cfg_addr] <= cfg_wdata;
            else         cfg_err <= 1'b1;
          end
          if (commit_req) begin
            state         <= S_WAIT_GAP;
            busy          <= 1'b1;
            verify_err    <= 1'b0;
            forced_commit <= 1'b0;
            gap_cnt       <= '0;
          end
        end

        S_WAIT_GAP: begin
          if (!valid_in) begin
            state       <= S_COMMIT;
            coeff_wr_en <= 1'b1;
          end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
            state         <= S_COMMIT;
            coeff_wr_en   <= 1'b1;
            forced_commit <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_COMMIT: state <= S_VERIFY;

        S_VERIFY: begin
          if (coeff_out != shadow) verify_err <= 1'b1;
          if (SETTLE_SAMPLES > 0) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            iir_bypass <= 1'b1;
          end else begin
            state       <= S_DONE;
            commit_done <= 1'b1;
          end
        end

        S_SETTLE: begin
          iir_bypass <= 1'b1;
          if (valid_in) begin
            if (settle_cnt == SW'(SETTLE_SAMPLES - 1)) begin
              state       <= S_DONE;
              commit_done <= 1'b1;
              iir_bypass  <= bypass_cfg;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl with a loop-back filter model that can
// hold coefficient entry 2 stuck at zero.
module tb_iir_coeff_ctrl;
  localparam int W = 20;
  localparam int D = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_wr_en, preset_load, commit_req, bypass_cfg, valid_in, stuck;
  logic [2:0] cfg_addr, cfg_rd_addr;
  logic [1:0] preset_sel;
  logic [W-1:0] cfg_wdata, cfg_rdata, live_rdata;
  logic coeff_wr_en, iir_bypass, busy, commit_done, cfg_err, verify_err, forced_commit;
  logic [D-1:0][W-1:0] coeff_in, coeff_out, live;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [W-1:0] P2[D] = '{20'h37061, 20'h5907c, 20'h37061, 20'h5907c, 20'h2e0c3};
  localparam logic [W-1:0] PM[D] = '{20'h37061, 20'hc8f9f, 20'h37061, 20'hc8f9f, 20'h12345};
  localparam logic [W-1:0] P1[D] = '{20'h37061, 20'h37061, 20'h37061, 20'h37061, 20'h2e0c3};

  iir_coeff_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rd_addr(cfg_rd_addr), .cfg_rdata(cfg_rdata), .live_rdata(live_rdata),
    .preset_load(preset_load), .preset_sel(preset_sel), .commit_req(commit_req),
    .bypass_cfg(bypass_cfg), .valid_in(valid_in), .coeff_wr_en(coeff_wr_en),
    .coeff_in(coeff_in), .coeff_out(coeff_out), .iir_bypass(iir_bypass),
    .busy(busy), .commit_done(commit_done), .cfg_err(cfg_err),
    .verify_err(verify_err), .forced_commit(forced_commit)
  );

  // Loop-back filter: latches the bank on the write pulse.
  always @(posedge clk) begin
    if (rst) live <= '0;
    else if (coeff_wr_en) live <= coeff_in;
  end

  always_comb begin
    coeff_out = live;
    if (stuck) coeff_out[2] = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (commit_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cfg_rd_addr = 3'd1;
    #1;
    n_checks++;
    if (cfg_rdata !== 20'h5907c) begin
      n_fail++;
      $display("FAIL reset_rdata1: got %h want 5907c", cfg_rdata);
    end
    n_checks++;
    if ({coeff_wr_en, iir_bypass, busy, commit_done, cfg_err, verify_err, forced_commit} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000",
               {coeff_wr_en, iir_bypass, busy, commit_done, cfg_err, verify_err, forced_commit});
    end
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (coeff_in[i] !== P2[i]) begin
        n_fail++;
        $display("FAIL reset_bank[%0d]: got %h want %h", i, coeff_in[i], P2[i]);
      end
    end
  endtask

  task automatic test_commit();
    int n;
    preset_load = 1'b1;
    preset_sel = 2'd0;
    tick();
    preset_load = 1'b0;
    cfg_wr_en = 1'b1;
    cfg_addr = 3'd4;
    cfg_wdata = 20'h12345;
    tick();
    cfg_wr_en = 1'b0;
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (coeff_in[i] !== PM[i]) begin
        n_fail++;
        $display("FAIL commit_bank[%0d]: got %h want %h", i, coeff_in[i], PM[i]);
      end
    end
    valid_in = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_checks++;
    if (coeff_wr_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_t1: wr_en %b busy %b want 0 1", coeff_wr_en, busy);
    end
    tick();
    n_checks++;
    if (coeff_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_t2_wr: got %b want 1", coeff_wr_en);
    end
    tick();
    n_checks++;
    if (coeff_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_t3_wr: got %b want 0", coeff_wr_en);
    end
    tick();
    n_checks++;
    if (iir_bypass !== 1'b1 || verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_settle: bypass %b verr %b want 1 0", iir_bypass, verify_err);
    end
    for (int s = 0; s < 3; s++) begin
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      n_checks++;
      if (commit_done !== 1'b0 || iir_bypass !== 1'b1) begin
        n_fail++;
        $display("FAIL settle_sample%0d: done %b bypass %b want 0 1", s, commit_done, iir_bypass);
      end
    end
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    n_checks++;
    if (commit_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_done_pulse: done %b busy %b want 1 1", commit_done, busy);
    end
    tick();
    n_checks++;
    if (commit_done !== 1'b0 || busy !== 1'b0 || iir_bypass !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_idle: done %b busy %b bypass %b want 0 0 0", commit_done, busy, iir_bypass);
    end
    cfg_rd_addr = 3'd4;
    #1;
    n_checks++;
    if (live_rdata !== 20'h12345) begin
      n_fail++;
      $display("FAIL live_rdata4: got %h want 12345", live_rdata);
    end
    cfg_rd_addr = 3'd5;
    #1;
    n_checks++;
    if (cfg_rdata !== 20'h0) begin
      n_fail++;
      $display("FAIL rdata_oob: got %h want 0", cfg_rdata);
    end
    n = 0;
  endtask

  task automatic test_forced_commit();
    int n;
    valid_in = 1'b1;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n = 0;
    while (coeff_wr_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL forced_latency: got %0d cycles want 64", n);
    end
    n_checks++;
    if (forced_commit !== 1'b1) begin
      n_fail++;
      $display("FAIL forced_flag: got %b want 1", forced_commit);
    end
    run_to_done(n);
    n_checks++;
    if (commit_done !== 1'b1) begin
      n_fail++;
      $display("FAIL forced_done: done %b after %0d cycles want 1", commit_done, n);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_verify_err();
    int n;
    stuck = 1'b1;
    valid_in = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_checks++;
    if (forced_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_clear: got %b want 0", forced_commit);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (verify_err !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_set: got %b want 1", verify_err);
    end
    valid_in = 1'b1;
    run_to_done(n);
    valid_in = 1'b0;
    tick();
    n_checks++;
    if (verify_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_sticky: verr %b busy %b want 1 0", verify_err, busy);
    end
    stuck = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_checks++;
    if (verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_clear: got %b want 0", verify_err);
    end
    tick();
    valid_in = 1'b1;
    run_to_done(n);
    valid_in = 1'b0;
    n_checks++;
    if (commit_done !== 1'b1 || verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_clean: done %b verr %b want 1 0", commit_done, verify_err);
    end
    tick();
  endtask

  task automatic test_cfg_errors();
    int n;
    cfg_wr_en = 1'b1;
    cfg_addr = 3'd6;
    cfg_wdata = 20'habcde;
    tick();
    cfg_wr_en = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_addr6: got %b want 1", cfg_err);
    end
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: got %b want 0", cfg_err);
    end
    preset_load = 1'b1;
    preset_sel = 2'd3;
    tick();
    preset_load = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sel3: got %b want 1", cfg_err);
    end
    for (int i = 0; i < D; i++) begin
      cfg_rd_addr = 3'(i);
      #1;
      n_checks++;
      if (cfg_rdata !== PM[i]) begin
        n_fail++;
        $display("FAIL err_bank_kept[%0d]: got %h want %h", i, cfg_rdata, PM[i]);
      end
    end
    preset_load = 1'b1;
    preset_sel = 2'd1;
    cfg_wr_en = 1'b1;
    cfg_addr = 3'd4;
    cfg_wdata = 20'h00000;
    tick();
    preset_load = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_rd_addr = 3'd4;
    #1;
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_rdata !== 20'h2e0c3) begin
      n_fail++;
      $display("FAIL err_preset_vs_wr: err %b rdata %h want 1 2e0c3", cfg_err, cfg_rdata);
    end
    valid_in = 1'b1;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_addr = 3'd0;
    cfg_wdata = 20'h00000;
    tick();
    commit_req = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_rd_addr = 3'd0;
    #1;
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_rdata !== P1[0]) begin
      n_fail++;
      $display("FAIL err_busy_wr: err %b rdata %h want 1 %h", cfg_err, cfg_rdata, P1[0]);
    end
    valid_in = 1'b0;
    tick();
    valid_in = 1'b1;
    run_to_done(n);
    valid_in = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || live_rdata !== P1[0]) begin
      n_fail++;
      $display("FAIL err_busy_commit: busy %b live %h want 0 %h", busy, live_rdata, P1[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_wr_en = 1'b1;
    cfg_addr = 3'd0;
    cfg_wdata = 20'h11111;
    commit_req = 1'b1;
    valid_in = 1'b0;
    tick();
    cfg_wr_en = 1'b0;
    commit_req = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: err %b busy %b want 0 1", cfg_err, busy);
    end
    tick();
    valid_in = 1'b1;
    run_to_done(n);
    valid_in = 1'b0;
    tick();
    cfg_rd_addr = 3'd0;
    #1;
    n_checks++;
    if (live_rdata !== 20'h11111 || verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_live0: live %h verr %b want 11111 0", live_rdata, verify_err);
    end
  endtask

  task automatic test_reset_in_settle();
    int wr_seen;
    valid_in = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (iir_bypass !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_settle: bypass %b busy %b want 1 1", iir_bypass, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_rd_addr = 3'd1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || iir_bypass !== 1'b0 || commit_done !== 1'b0 || cfg_rdata !== 20'h5907c) begin
      n_fail++;
      $display("FAIL rst_settle: busy %b bypass %b done %b rdata %h want 0 0 0 5907c",
               busy, iir_bypass, commit_done, cfg_rdata);
    end
    valid_in = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (coeff_wr_en === 1'b1 || busy === 1'b1) wr_seen++;
    end
    n_checks++;
    if (wr_seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_write: got %0d active cycles want 0", wr_seen);
    end
    bypass_cfg = 1'b1;
    tick();
    tick();
    n_checks++;
    if (iir_bypass !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_bypass: got %b want 1", iir_bypass);
    end
    bypass_cfg = 1'b0;
    valid_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_addr = 3'd0;
    cfg_wdata = '0;
    cfg_rd_addr = 3'd0;
    preset_load = 1'b0;
    preset_sel = 2'd0;
    commit_req = 1'b0;
    bypass_cfg = 1'b0;
    valid_in = 1'b0;
    stuck = 1'b0;
    test_reset();
    test_commit();
    test_forced_commit();
    test_verify_err();
    test_cfg_errors();
    test_back_to_back();
    test_reset_in_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_coeff_ctrl.md
Name: iir_coeff_ctrl

Overview:
- Configuration controller for the biquad notch IIR stage.
- Holds a 5-entry shadow coefficient bank (B0, B1, B2, A1, A2), written from a register interface or loaded from the built-in notch presets.
- Commits the bank atomically to the filter through its `coeff_wr_en` / `coeff_in` port during an idle sample slot, then verifies the readback.
- Masks the post-update transient by forcing filter bypass for a programmable number of samples.

Parameters:
- COEFF_WIDTH, 20, coefficient word width (signed, Q2.18).
- COEFF_DEPTH, 5, number of coefficients (B0, B1, B2, A1, A2 at addresses 0..4).
- NOTCH_DEFAULT, 2, preset loaded into the shadow bank at reset (0: 1 MHz, 1: 2 MHz, 2: 2.4 MHz).
- GAP_TIMEOUT, 64, maximum cycles to wait for an idle sample slot before a forced commit.
- SETTLE_SAMPLES, 4, number of valid samples the filter is bypassed after a commit (0 disables).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cfg_wr_en  input  1  shadow write strobe
- cfg_addr  input  3  shadow write address
- cfg_wdata  input  COEFF_WIDTH  shadow write data (signed)
- cfg_rd_addr  input  3  readback address
- cfg_rdata  output  COEFF_WIDTH  shadow readback data
- live_rdata  output  COEFF_WIDTH  live filter coefficient readback, from `coeff_out[cfg_rd_addr]`
- preset_load  input  1  load the preset selected by `preset_sel` into the shadow bank
- preset_sel  input  2  0: 1 MHz, 1: 2 MHz, 2: 2.4 MHz, 3: invalid
- commit_req  input  1  request a commit of the shadow bank to the filter
- bypass_cfg  input  1  software bypass request
- valid_in  input  1  filter sample strobe (same signal that drives the filter)
- coeff_wr_en  output  1  filter coefficient write pulse
- coeff_in  output  COEFF_WIDTH x COEFF_DEPTH  shadow bank, driven to the filter
- coeff_out  input  COEFF_WIDTH x COEFF_DEPTH  live coefficients read back from the filter
- iir_bypass  output  1  filter bypass control
- busy  output  1  commit sequence in progress
- commit_done  output  1  one-cycle pulse at the end of a commit sequence
- cfg_err  output  1  one-cycle pulse when a request is rejected
- verify_err  output  1  sticky verify-mismatch flag; cleared by `rst` or by the next `commit_req`
- forced_commit  output  1  sticky flag, set when a commit was forced by timeout; cleared like `verify_err`

Behaviour:
Reset (`rst` sampled at a `clk` edge):
- State IDLE; shadow bank = NOTCH_DEFAULT preset.
- `coeff_wr_en`, `iir_bypass`, `busy`, `commit_done`, `cfg_err`, `verify_err`, `forced_commit` = 0; all counters = 0.
- `rst` mid-sequence aborts immediately; no write pulse is issued after the reset edge.

Preset tables (B0, B1, B2, A1, A2, hex):
- preset 0: 37061, c8f9f, 37061, c8f9f, 2e0c3
- preset 1: 37061, 37061, 37061, 37061, 2e0c3
- preset 2: 37061, 5907c, 37061, 5907c, 2e0c3

Shadow access (IDLE only, registered, takes effect the next cycle):
- `cfg_wr_en` with `cfg_addr` <= 4 writes one entry.
- `cfg_addr` >= 5 gives a `cfg_err` pulse; no write.
- `preset_load` with `preset_sel` <= 2 overwrites all 5 entries; `preset_sel` = 3 gives `cfg_err`, bank unchanged.
- `preset_load` and `cfg_wr_en` in the same cycle: preset applies, write is dropped, `cfg_err` pulses.
- `cfg_wr_en`, `preset_load` or `commit_req` while `busy` = 1: dropped, `cfg_err` pulses.
- `commit_req` together with a shadow write in IDLE: the write applies first, and the commit uses the updated bank.
- `cfg_rdata` = shadow[`cfg_rd_addr`], combinational; returns 0 for addresses >= 5. `live_rdata` follows the same addressing on `coeff_out`.
- `coeff_in` continuously reflects the shadow bank.

State machine (all outputs registered):
- IDLE
  - `commit_req` goes to WAIT_GAP, sets `busy`, clears `verify_err`, `forced_commit` and the gap counter.
- WAIT_GAP
  - `valid_in` = 0 goes to COMMIT.
  - Otherwise the gap counter increments; when it reaches GAP_TIMEOUT - 1 with `valid_in` still 1, set `forced_commit` and go to COMMIT.
- COMMIT
  - `coeff_wr_en` = 1 for exactly this one cycle; then go to VERIFY.
- VERIFY
  - Compare all 5 `coeff_out` entries with the shadow bank; any mismatch sets `verify_err`.
  - Go to SETTLE if SETTLE_SAMPLES > 0, else DONE.
- SETTLE
  - `iir_bypass` forced to 1.
  - Counts `valid_in` cycles; after SETTLE_SAMPLES counted samples, go to DONE.
- DONE
  - `commit_done` = 1 for one cycle, `busy` deasserts, return to IDLE.

Latency and output rules:
- Latency with an idle slot available: `commit_req` at T, WAIT_GAP at T+1; if `valid_in` = 0 at T+1, `coeff_wr_en` = 1 at T+2, VERIFY at T+3.
- `iir_bypass` = `bypass_cfg` OR (state == SETTLE).
- `busy` = 1 in every state except IDLE.

Test Plan:
- Reset, then `cfg_rd_addr` = 1 -> `cfg_rdata` = 0x5907C; all flags and `coeff_wr_en` = 0.
- `preset_load`, `preset_sel` = 0, then write addr 4 = 0x12345 and commit with `valid_in` = 0 -> `coeff_wr_en` pulses 1 cycle at T+2, `coeff_in` = {37061, c8f9f, 37061, c8f9f, 12345}; with a loop-backed filter model, `verify_err` stays 0 and `commit_done` pulses after 4 counted samples.
- Hold `valid_in` = 1 continuously, `commit_req` -> forced commit after 64 WAIT_GAP cycles, `forced_commit` = 1.
- `coeff_out` model with entry 2 stuck at 0 -> `verify_err` = 1 after VERIFY; the next `commit_req` clears it.
- Write to addr 6, `preset_sel` = 3, and `cfg_wr_en` while `busy` -> `cfg_err` pulses each time, shadow unchanged.
- Assert `rst` during SETTLE -> next cycle IDLE, `iir_bypass` = `bypass_cfg`, `busy` = 0, shadow = preset 2.
